// File: rtl/ltc2324_frame_packer_if.sv
// Packed output beat stream of the LTC2324 frame packer.
// The master drives data/valid/last and the slave returns ready.
interface ltc2324_frame_packer_if;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;

   modport master (
      output m_axis_tdata,
      output m_axis_tvalid,
      output m_axis_tlast,
      input  m_axis_tready
   );

   modport slave (
      input  m_axis_tdata,
      input  m_axis_tvalid,
      input  m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/ltc2324_frame_packer.sv
// Captures one sample from each of four LTC2324 channel FIFOs as an atomic set and
// emits it as two 32-bit beats, marking the last beat of every FRAME_LEN-set frame.
module ltc2324_frame_packer #(
   parameter int unsigned FRAME_LEN  = 256,
   parameter int unsigned SKEW_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          clear_err,
   input  logic [15:0]                   s_ch1_tdata,
   input  logic [15:0]                   s_ch2_tdata,
   input  logic [15:0]                   s_ch3_tdata,
   input  logic [15:0]                   s_ch4_tdata,
   input  logic                          s_ch1_tvalid,
   input  logic                          s_ch2_tvalid,
   input  logic                          s_ch3_tvalid,
   input  logic                          s_ch4_tvalid,
   output logic                          s_ch1_tready,
   output logic                          s_ch2_tready,
   output logic                          s_ch3_tready,
   output logic                          s_ch4_tready,
   ltc2324_frame_packer_if.master        m_axis,
   output logic                          desync_err,
   output logic [15:0]                   set_cnt
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      BEAT0   = 2'd1,
      BEAT1   = 2'd2
   } state_t;

   localparam logic [7:0]  SKEW_MAX  = 8'(SKEW_LIMIT);
   localparam logic [16:0] FRAME_END = 17'(FRAME_LEN);

   state_t      state;
   logic [15:0] hold_ch1;
   logic [15:0] hold_ch2;
   logic [15:0] hold_ch3;
   logic [15:0] hold_ch4;
   logic [7:0]  skew_cnt;
   logic [3:0]  valid_vec;
   logic        all_valid;
   logic        mixed_valid;
   logic        capture;
   logic        beat_done;
   logic        last_set;
   logic        skew_hit;

   assign valid_vec   = {s_ch4_tvalid, s_ch3_tvalid, s_ch2_tvalid, s_ch1_tvalid};
   assign all_valid   = &valid_vec;
   assign mixed_valid = (|valid_vec) && !all_valid;

   // All four channels are accepted together or not at all; rst_n keeps the
   // sources from seeing a handshake while the block is held in reset.
   assign capture      = rst_n && enable && all_valid && (state == COLLECT);
   assign s_ch1_tready = capture;
   assign s_ch2_tready = capture;
   assign s_ch3_tready = capture;
   assign s_ch4_tready = capture;

   assign beat_done = m_axis.m_axis_tvalid && m_axis.m_axis_tready;
   assign last_set  = ({1'b0, set_cnt} + 17'd1) == FRAME_END;
   assign skew_hit  = (state == COLLECT) && mixed_valid && (skew_cnt >= SKEW_MAX - 8'd1);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      m_axis.m_axis_tdata = '0;
      if (state == BEAT0) begin
         m_axis.m_axis_tdata = {hold_ch2, hold_ch1};
      end else if (state == BEAT1) begin
         m_axis.m_axis_tdata = {hold_ch4, hold_ch3};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= COLLECT;
         m_axis.m_axis_tvalid <= 1'b0;
         m_axis.m_axis_tlast  <= 1'b0;
         set_cnt              <= '0;
         hold_ch1             <= '0;
         hold_ch2             <= '0;
         hold_ch3             <= '0;
         hold_ch4             <= '0;
      end else begin
         unique case (state)
            COLLECT: begin
               if (capture) begin
                  hold_ch1             <= s_ch1_tdata;
                  hold_ch2             <= s_ch2_tdata;
                  hold_ch3             <= s_ch3_tdata;
                  hold_ch4             <= s_ch4_tdata;
                  m_axis.m_axis_tvalid <= 1'b1;
                  m_axis.m_axis_tlast  <= 1'b0;
                  state                <= BEAT0;
               end
            end
            BEAT0: begin
               if (beat_done) begin
                  m_axis.m_axis_tlast <= last_set;
                  state               <= BEAT1;
               end
            end
            BEAT1: begin
               if (beat_done) begin
                  m_axis.m_axis_tvalid <= 1'b0;
                  m_axis.m_axis_tlast  <= 1'b0;
                  set_cnt              <= last_set ? 16'd0 : set_cnt + 16'd1;
                  state                <= COLLECT;
               end
            end
            default: begin
               m_axis.m_axis_tvalid <= 1'b0;
               m_axis.m_axis_tlast  <= 1'b0;
               state                <= COLLECT;
            end
         endcase
      end
   end

   // Skew is only meaningful while waiting for a set; the error latches until cleared,
   // and a persisting skew wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skew_cnt   <= '0;
         desync_err <= 1'b0;
      end else begin
         if ((state == COLLECT) && mixed_valid) begin
            if (skew_cnt != SKEW_MAX) begin
               skew_cnt <= skew_cnt + 8'd1;
            end
         end else begin
            skew_cnt <= '0;
         end

         if (skew_hit) begin
            desync_err <= 1'b1;
         end else if (clear_err) begin
            desync_err <= 1'b0;
         end
      end
   end

endmodule
